// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e   : controller states (IDLE, CALC, FIX, DONE)
//   div_cnt_width : width of the iteration counter for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivCalc = 2'd1,
        DivFix  = 2'd2,
        DivDone = 2'd3
    } div_state_e;

    // Counter must hold Width-1; never narrower than one bit.
    function automatic int div_cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement negation.
//   value  : operand
//   negate : 1 = return -value, 0 = pass value through
//   result : value or its two's-complement negation (wraps at Width bits)
module abs_neg #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             negate,
    output logic [Width-1:0] result
);

    // Negate as invert-plus-one; the most negative value maps to itself.
    always_comb begin
        result = value;
        if (negate) begin
            result = (~value) + {{(Width-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Fixed latency: accept at edge T, done_o high in cycle T+Width+2.
//   clk_i       : clock
//   rst_ni      : synchronous active-low reset
//   start_i     : request, accepted only in IDLE
//   signed_i    : 1 = two's-complement divide, 0 = unsigned; sampled at accept
//   dividend_i  : numerator, sampled at accept
//   divisor_i   : denominator, sampled at accept
//   flush_i     : abort any in-flight operation
//   busy_o      : high from the cycle after accept through the DONE cycle
//   done_o      : one-cycle pulse, results valid
//   quotient_o  : quotient (LO)
//   remainder_o : remainder (HI)
module iter_divider
    import div_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o
);

    localparam int CntW = div_cnt_width(Width);

    div_state_e        state_r;
    logic [CntW-1:0]   cnt_r;
    // Dividend magnitude shifts out MSB first; quotient bits shift in at the
    // LSB, so after Width iterations this register holds the raw quotient.
    logic [Width-1:0]  dvd_r;
    logic [Width-1:0]  dvs_r;
    logic [Width-1:0]  rem_r;
    logic              q_neg_r;
    logic              r_neg_r;
    logic              busy_r;
    logic              done_r;
    logic [Width-1:0]  quotient_r;
    logic [Width-1:0]  remainder_r;

    logic              dvd_neg_s;
    logic              dvs_neg_s;
    logic [Width-1:0]  dvd_mag_s;
    logic [Width-1:0]  dvs_mag_s;
    logic [Width-1:0]  q_fix_s;
    logic [Width-1:0]  r_fix_s;
    logic [Width:0]    trial_s;
    logic              q_bit_s;
    logic [Width-1:0]  rem_next_s;

    assign dvd_neg_s = signed_i & dividend_i[Width-1];
    assign dvs_neg_s = signed_i & divisor_i[Width-1];

    abs_neg #(.Width(Width)) u_dvd_mag (
        .value  (dividend_i),
        .negate (dvd_neg_s),
        .result (dvd_mag_s)
    );

    abs_neg #(.Width(Width)) u_dvs_mag (
        .value  (divisor_i),
        .negate (dvs_neg_s),
        .result (dvs_mag_s)
    );

    abs_neg #(.Width(Width)) u_q_fix (
        .value  (dvd_r),
        .negate (q_neg_r),
        .result (q_fix_s)
    );

    abs_neg #(.Width(Width)) u_r_fix (
        .value  (rem_r),
        .negate (r_neg_r),
        .result (r_fix_s)
    );

    // One restoring step: the kept partial remainder is always below the
    // divisor, so the Width+1-bit trial's top bit is its sign.
    always_comb begin
        trial_s    = {rem_r, dvd_r[Width-1]} - {1'b0, dvs_r};
        q_bit_s    = ~trial_s[Width];
        rem_next_s = {rem_r[Width-2:0], dvd_r[Width-1]};
        if (q_bit_s) begin
            rem_next_s = trial_s[Width-1:0];
        end else begin
            rem_next_s = {rem_r[Width-2:0], dvd_r[Width-1]};
        end
    end

    // Controller and datapath state; reset beats flush beats start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= DivIdle;
            cnt_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            case (state_r)
                DivIdle: begin
                    done_r <= 1'b0;
                    if (start_i && !flush_i) begin
                        state_r <= DivCalc;
                        busy_r  <= 1'b1;
                        cnt_r   <= CntW'(Width - 1);
                        dvd_r   <= dvd_mag_s;
                        dvs_r   <= dvs_mag_s;
                        rem_r   <= '0;
                        q_neg_r <= dvd_neg_s ^ dvs_neg_s;
                        r_neg_r <= dvd_neg_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                DivCalc: begin
                    if (flush_i) begin
                        state_r <= DivIdle;
                        busy_r  <= 1'b0;
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= {dvd_r[Width-2:0], q_bit_s};
                        if (cnt_r == '0) begin
                            state_r <= DivFix;
                        end else begin
                            cnt_r <= cnt_r - CntW'(1);
                        end
                    end
                end
                DivFix: begin
                    if (flush_i) begin
                        state_r <= DivIdle;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r     <= DivDone;
                        done_r      <= 1'b1;
                        quotient_r  <= q_fix_s;
                        remainder_r <= r_fix_s;
                    end
                end
                DivDone: begin
                    state_r <= DivIdle;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= DivIdle;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_r;
    // A flush arriving in the DONE cycle must suppress the pulse in that
    // same cycle, so the registered flag is qualified by the live flush.
    assign done_o      = done_r & ~flush_i;
    assign quotient_o  = quotient_r;
    assign remainder_o = remainder_r;

endmodule
